// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the synchronous IROM address and
// offers {pc4, pc} to ID over the valid/allow_in handshake, applying redirects.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_allow_in,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        trap_valid,
    input  logic [31:0] trap_target,
    output logic [31:0] irom_addr,
    output logic [63:0] if_to_id_bus,
    output logic        if_to_id_valid,
    output logic [31:0] if_fetch_cnt
);

    logic [31:0] if_pc_q, if_pc_d;
    logic        if_valid_q;
    logic [31:0] addr_q;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;

    logic        redirect;
    logic [31:0] redir_pc;
    logic [31:0] pc4;
    logic        fire;

    assign redirect       = trap_valid | br_taken;
    assign redir_pc       = trap_valid ? trap_target : br_target;
    assign pc4            = if_pc_q + 32'd4;
    assign if_to_id_valid = if_valid_q & ~redirect;
    assign if_to_id_bus   = {pc4, if_pc_q};
    assign fire           = if_to_id_valid & id_allow_in;
    // While ID stalls, keep presenting the address of the instruction it holds.
    assign irom_addr      = fire ? if_pc_q : addr_q;
    assign if_fetch_cnt   = fetch_cnt_q;

    always_comb begin
        // NOTE: default every always_comb output first so no path infers a latch.
        if_pc_d     = if_pc_q;
        fetch_cnt_d = fetch_cnt_q;
        if (redirect) begin
            if_pc_d = redir_pc & ~32'd3;
        end else if (fire) begin
            if_pc_d     = pc4;
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_pc_q     <= RESET_PC;
            if_valid_q  <= 1'b0;
            addr_q      <= RESET_PC;
            fetch_cnt_q <= 32'd0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            if_pc_q     <= if_pc_d;
            if_valid_q  <= 1'b1;
            addr_q      <= irom_addr;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage RV32I pipeline; the producer side of the IF->ID valid/allow_in handshake.
- Owns the PC register and drives the synchronous IROM address, so the instruction word for the PC held in ID appears on irom_inst in the cycle ID decodes it.
- Applies redirects: trap/mret from the CSR unit, taken branch/jump from EX.
- Squashes wrong-path fetches and keeps a count of accepted fetches.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_allow_in  in  1  ID can accept a new instruction this cycle.
- br_taken  in  1  EX resolved a taken branch/jump this cycle (same signal ID uses to cancel).
- br_target  in  32  branch/jump target PC.
- trap_valid  in  1  CSR unit requests a redirect (exception, interrupt or mret).
- trap_target  in  32  mtvec or mepc target.
- irom_addr  out  32  IROM read address; data returns on irom_inst next cycle.
- if_to_id_bus  out  64  {pc4, pc} of the instruction offered to ID.
- if_to_id_valid  out  1  if_to_id_bus holds a valid, non-squashed instruction.
- if_fetch_cnt  out  32  number of instructions accepted by ID since reset.

Behaviour:
- State registers:
  - if_pc (32), reset RESET_PC.
  - if_valid (1), reset 0.
  - addr_q (32, last driven irom_addr), reset RESET_PC.
  - fetch_cnt (32), reset 0.
- Outputs during reset: irom_addr = RESET_PC, if_to_id_valid = 0, if_to_id_bus = {RESET_PC+4, RESET_PC}, if_fetch_cnt = 0.
- Reset is asynchronous assert; all registers return to reset values immediately, including mid-stall or mid-redirect.
- Startup: in the first edge after rst_n deasserts, if_valid <= 1 and if_pc stays RESET_PC.
- Combinational outputs:
  - redirect = trap_valid | br_taken.
  - redir_pc = trap_valid ? trap_target : br_target. Trap has priority over branch when both are asserted.
  - if_to_id_valid = if_valid & ~redirect.
  - if_to_id_bus = {if_pc + 4 (mod 2^32, wraps at 32'hFFFF_FFFC to 0), if_pc}.
  - fire = if_to_id_valid & id_allow_in.
  - irom_addr = fire ? if_pc : addr_q. When ID stalls, the IROM keeps presenting the instruction ID holds.
- Every edge: addr_q <= irom_addr.
- PC update, evaluated in priority order:
  1. redirect: if_pc <= {redir_pc[31:2], 2'b00}; if_valid <= 1. The current IF instruction is discarded and fetch_cnt is unchanged. Target bits [1:0] are ignored; misalignment is flagged upstream by EX/CSR.
  2. fire: if_pc <= if_pc + 4; fetch_cnt <= fetch_cnt + 1, wrapping at 2^32.
  3. Otherwise (stall, or not yet valid after reset): if_pc holds. if_valid <= 1 after the startup cycle.
- Latency:
  - An instruction at PC X reaches ID one cycle after fire with pc = X; irom_inst = IROM[X] in that cycle.
  - After a redirect in cycle t, the target is offered to ID in cycle t+1 and enters ID at t+2.
- The bus is stable while if_to_id_valid = 1 and id_allow_in = 0.
- A redirect arriving during an ID stall overrides the stall.

Test Plan:
1. Reset release, id_allow_in = 1 constant -> if_to_id_valid rises 1 cycle after release; pc sequence 0,4,8,12; irom_addr equals the bus pc on each fire cycle; if_fetch_cnt = 4 after 4 fires.
2. id_allow_in = 0 for 3 cycles while pc = 0x10 -> bus holds {0x14, 0x10}; irom_addr holds 0x0C (the previous fire address); on release, fire at 0x10 and irom_addr = 0x10; no pc is skipped.
3. br_taken = 1, br_target = 0x200 while if_pc = 0x40 -> if_to_id_valid = 0 that cycle; next cycle pc = 0x200, pc4 = 0x204; fetch_cnt unchanged for 0x40.
4. trap_valid = 1 (trap_target = 0x100) together with br_taken = 1 (br_target = 0x200) -> next pc = 0x100.
5. Redirect during an ID stall, and br_target = 0x203 -> stall overridden, next pc = 0x200; with if_pc = 0xFFFF_FFFC, pc4 = 0.
6. Assert rst_n low asynchronously mid-stream (pc = 0x80) -> outputs go to reset values immediately without a clock edge; restart from RESET_PC.
